// File: rtl/fcc_scan_pkg.sv
// Shared types and constants for the FCC neighbour scan sequencer.
package fcc_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    localparam int SLOT_N      = 9;
    localparam int CENTRE_SLOT = 4;

    localparam logic [3:0] LAST_SLOT   = 4'(SLOT_N - 1);
    localparam logic [3:0] CENTRE_IDX  = 4'(CENTRE_SLOT);

    // Row/column offsets per slot as 2-bit two's complement, slot 0 in the LSBs.
    // Slot order: (-1,-1) (-1,0) (-1,+1) (0,-1) (0,0) (0,+1) (+1,-1) (+1,0) (+1,+1)
    localparam logic [SLOT_N-1:0][1:0] DR_TAB = {
        2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11
    };
    localparam logic [SLOT_N-1:0][1:0] DC_TAB = {
        2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11
    };

    // Wide all-ones; users truncate to their label width.
    localparam logic [63:0] LABEL_MAX = '1;

endpackage

// File: rtl/fcc_nbr_addr_gen.sv
// Combinational neighbour address generator: centre + slot -> address and bounds flag.
// Out-of-bounds slots return the centre address so the memory never sees a wrapped index.
module fcc_nbr_addr_gen
    import fcc_scan_pkg::*;
#(
    parameter int ROWS  = 30,
    parameter int COLS  = 30,
    parameter int COL_W = 5
) (
    input  logic [7:0]       ctr_row,
    input  logic [COL_W-1:0] ctr_col,
    input  logic [3:0]       slot,
    output logic [7:0]       row,
    output logic [COL_W-1:0] col,
    output logic             in_bounds
);

    logic [1:0]     dr;
    logic [1:0]     dc;
    logic [8:0]     row_x;
    logic [COL_W:0] col_x;
    logic           row_ok;
    logic           col_ok;

    // Offset add with one extra sign bit; a set MSB means the result went negative or overflowed.
    always_comb begin
        dr        = DR_TAB[slot];
        dc        = DC_TAB[slot];
        row_x     = {1'b0, ctr_row} + {{7{dr[1]}}, dr};
        col_x     = {1'b0, ctr_col} + {{(COL_W - 1){dc[1]}}, dc};
        row_ok    = !row_x[8] && (row_x[7:0] < 8'(ROWS));
        col_ok    = !col_x[COL_W] && (col_x < (COL_W + 1)'(COLS));
        in_bounds = row_ok && col_ok;
        row       = in_bounds ? row_x[7:0] : ctr_row;
        col       = in_bounds ? col_x[COL_W-1:0] : ctr_col;
    end

endmodule

// File: rtl/fcc_neighbor_scan_ctrl.sv
// Reads a centre cell and its 8 neighbours from the label memory, one per cycle,
// and reduces them to min neighbour label, qualifying count and centre status.
module fcc_neighbor_scan_ctrl
    import fcc_scan_pkg::*;
#(
    parameter int ROWS    = 30,
    parameter int COLS    = 30,
    parameter int COL_W   = 5,
    parameter int LABEL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_row,
    input  logic [COL_W-1:0]   req_col,
    output logic [7:0]         rd_row,
    output logic [COL_W-1:0]   rd_col,
    input  logic [LABEL_W-1:0] rd_label,
    input  logic               rd_is_ground,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [LABEL_W-1:0] res_min_label,
    output logic               res_found,
    output logic [3:0]         res_nbr_cnt,
    output logic [LABEL_W-1:0] res_center_label,
    output logic               res_center_ground,
    output logic               res_err,
    output logic               busy
);

    scan_state_t        state;
    logic [3:0]         slot;
    logic [7:0]         ctr_row;
    logic [COL_W-1:0]   ctr_col;

    // Slot tags travelling with the issued address, then delayed to line up with rd_label.
    logic               p_act, p_vld;
    logic [3:0]         p_slot;
    logic               d_act, d_vld;
    logic [3:0]         d_slot;

    logic [LABEL_W-1:0] acc_min;
    logic [3:0]         acc_cnt;
    logic [LABEL_W-1:0] c_label;
    logic               c_gnd;

    logic [7:0]         g_ctr_row;
    logic [COL_W-1:0]   g_ctr_col;
    logic [3:0]         g_slot;
    logic [7:0]         g_row;
    logic [COL_W-1:0]   g_col;
    logic               g_inb;

    logic               req_oor;
    logic               qual;
    logic [LABEL_W-1:0] nxt_min;
    logic [3:0]         nxt_cnt;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign req_oor   = (req_row >= 8'(ROWS)) || ({1'b0, req_col} >= (COL_W + 1)'(COLS));

    // In IDLE the generator prepares slot 0 of the incoming request; in SCAN it looks one slot ahead.
    always_comb begin
        g_ctr_row = ctr_row;
        g_ctr_col = ctr_col;
        g_slot    = 4'd0;
        if (state == IDLE) begin
            g_ctr_row = req_row;
            g_ctr_col = req_col;
        end else if (state == SCAN && slot != LAST_SLOT) begin
            g_slot = slot + 4'd1;
        end
    end

    fcc_nbr_addr_gen #(
        .ROWS (ROWS),
        .COLS (COLS),
        .COL_W(COL_W)
    ) u_addr_gen (
        .ctr_row  (g_ctr_row),
        .ctr_col  (g_ctr_col),
        .slot     (g_slot),
        .row      (g_row),
        .col      (g_col),
        .in_bounds(g_inb)
    );

    // Running reduction including the data arriving this cycle; DRAIN uses it to fold in slot 8.
    always_comb begin
        qual    = d_act && d_vld && (d_slot != CENTRE_IDX) &&
                  (rd_label != '0) && !rd_is_ground;
        nxt_cnt = acc_cnt + {3'd0, qual};
        nxt_min = (qual && rd_label < acc_min) ? rd_label : acc_min;
    end

    // Sequencer FSM, read pipeline and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            slot              <= 4'd0;
            ctr_row           <= '0;
            ctr_col           <= '0;
            rd_row            <= '0;
            rd_col            <= '0;
            p_act             <= 1'b0;
            p_vld             <= 1'b0;
            p_slot            <= 4'd0;
            d_act             <= 1'b0;
            d_vld             <= 1'b0;
            d_slot            <= 4'd0;
            acc_min           <= '0;
            acc_cnt           <= 4'd0;
            c_label           <= '0;
            c_gnd             <= 1'b0;
            res_valid         <= 1'b0;
            res_min_label     <= '0;
            res_found         <= 1'b0;
            res_nbr_cnt       <= 4'd0;
            res_center_label  <= '0;
            res_center_ground <= 1'b0;
            res_err           <= 1'b0;
        end else begin
            p_act  <= 1'b0;
            d_act  <= p_act;
            d_vld  <= p_vld;
            d_slot <= p_slot;

            if (d_act) begin
                acc_cnt <= nxt_cnt;
                acc_min <= nxt_min;
                if (d_slot == CENTRE_IDX) begin
                    c_label <= rd_label;
                    c_gnd   <= rd_is_ground;
                end
            end

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_oor) begin
                            state     <= DONE;
                            res_valid <= 1'b1;
                            res_err   <= 1'b1;
                        end else begin
                            state   <= SCAN;
                            slot    <= 4'd0;
                            ctr_row <= req_row;
                            ctr_col <= req_col;
                            rd_row  <= g_row;
                            rd_col  <= g_col;
                            p_act   <= 1'b1;
                            p_vld   <= g_inb;
                            p_slot  <= 4'd0;
                            acc_min <= LABEL_W'(LABEL_MAX);
                            acc_cnt <= 4'd0;
                        end
                    end
                end
                SCAN: begin
                    if (slot == LAST_SLOT) begin
                        state <= DRAIN;
                        slot  <= 4'd0;
                    end else begin
                        slot   <= g_slot;
                        rd_row <= g_row;
                        rd_col <= g_col;
                        p_act  <= 1'b1;
                        p_vld  <= g_inb;
                        p_slot <= g_slot;
                    end
                end
                DRAIN: begin
                    state             <= DONE;
                    res_valid         <= 1'b1;
                    res_found         <= (nxt_cnt != 4'd0);
                    res_nbr_cnt       <= nxt_cnt;
                    res_min_label     <= (nxt_cnt != 4'd0) ? nxt_min : '0;
                    res_center_label  <= c_label;
                    res_center_ground <= c_gnd;
                end
                DONE: begin
                    if (res_ready) begin
                        state             <= IDLE;
                        res_valid         <= 1'b0;
                        res_min_label     <= '0;
                        res_found         <= 1'b0;
                        res_nbr_cnt       <= 4'd0;
                        res_center_label  <= '0;
                        res_center_ground <= 1'b0;
                        res_err           <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcc_neighbor_scan_ctrl.sv
// Directed bench for fcc_neighbor_scan_ctrl with a registered-read label memory model.
module tb_fcc_neighbor_scan_ctrl;

    localparam int ROWS    = 30;
    localparam int COLS    = 30;
    localparam int COL_W   = 5;
    localparam int LABEL_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [7:0]         req_row = '0;
    logic [COL_W-1:0]   req_col = '0;
    logic [7:0]         rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [LABEL_W-1:0] rd_label = '0;
    logic               rd_is_ground = 1'b0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [LABEL_W-1:0] res_min_label;
    logic               res_found;
    logic [3:0]         res_nbr_cnt;
    logic [LABEL_W-1:0] res_center_label;
    logic               res_center_ground;
    logic               res_err;
    logic               busy;

    logic [LABEL_W-1:0] lab [ROWS][COLS];
    logic               gnd [ROWS][COLS];

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    bit saw_255 = 1'b0;
    bit rd_moved = 1'b0;
    bit mon_rd = 1'b0;
    int early_valid;

    fcc_neighbor_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .COL_W(COL_W), .LABEL_W(LABEL_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_row          (req_row),
        .req_col          (req_col),
        .rd_row           (rd_row),
        .rd_col           (rd_col),
        .rd_label         (rd_label),
        .rd_is_ground     (rd_is_ground),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_min_label    (res_min_label),
        .res_found        (res_found),
        .res_nbr_cnt      (res_nbr_cnt),
        .res_center_label (res_center_label),
        .res_center_ground(res_center_ground),
        .res_err          (res_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Memory with one-cycle registered read.
    always @(posedge clk) begin
        if (rd_row < 8'(ROWS) && rd_col < 5'(COLS)) begin
            rd_label     <= lab[rd_row][rd_col];
            rd_is_ground <= gnd[rd_row][rd_col];
        end else begin
            rd_label     <= '0;
            rd_is_ground <= 1'b0;
        end
    end

    // Address watchers: wrap to 255, and any move away from (29,29) while armed.
    always @(negedge clk) begin
        if (rd_row == 8'd255) saw_255 = 1'b1;
        if (mon_rd && (rd_row != 8'd29 || rd_col != 5'd29)) rd_moved = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                lab[r][c] = '0;
                gnd[r][c] = 1'b0;
            end
    endtask

    task automatic load_interior();
        clear_mem();
        lab[4][4] = 16'd7;
        lab[4][6] = 16'd3;
        lab[6][5] = 16'd9;
        lab[5][4] = 16'd2;
        gnd[5][4] = 1'b1;
        lab[5][5] = 16'd12;
    endtask

    // Present a request, wait for acceptance, return cycles from accept edge to res_valid.
    task automatic run_req(input logic [7:0] r, input logic [COL_W-1:0] c, output int l);
        @(negedge clk);
        chk("req_ready_before", req_ready, 1);
        req_row   = r;
        req_col   = c;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!res_valid && l < 40);
        if (!res_valid) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic check_res(input string t, input int mn, input int fd, input int cnt,
                             input int cl, input int cg, input int er);
        chk({t, "_min"},   res_min_label,     mn);
        chk({t, "_found"}, res_found,         fd);
        chk({t, "_cnt"},   res_nbr_cnt,       cnt);
        chk({t, "_clab"},  res_center_label,  cl);
        chk({t, "_cgnd"},  res_center_ground, cg);
        chk({t, "_err"},   res_err,           er);
    endtask

    task automatic release_res(input string t);
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk({t, "_rel_valid"}, res_valid, 0);
        chk({t, "_rel_ready"}, req_ready, 1);
        chk({t, "_rel_busy"},  busy,      0);
        chk({t, "_rel_min"},   res_min_label, 0);
    endtask

    initial begin
        clear_mem();
        #12;
        chk("rst_valid", res_valid, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy",  busy,      0);
        chk("rst_rdrow", rd_row,    0);
        chk("rst_rdcol", rd_col,    0);
        chk("rst_min",   res_min_label, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Interior centre
        load_interior();
        run_req(8'd5, 5'd5, lat);
        chk("int_lat", lat, 11);
        check_res("int", 3, 1, 3, 12, 0, 0);
        release_res("int");

        // Corner (0,0): last slot (1,1) in bounds, so rd ends there
        clear_mem();
        lab[0][1] = 16'd5;
        lab[1][0] = 16'd4;
        saw_255 = 1'b0;
        run_req(8'd0, 5'd0, lat);
        chk("cor_lat", lat, 11);
        check_res("cor", 4, 1, 2, 0, 0, 0);
        chk("cor_no255", saw_255, 0);
        chk("cor_rdrow", rd_row, 1);
        chk("cor_rdcol", rd_col, 1);
        release_res("cor");

        // Far corner, all zero; slot 8 out of bounds leaves rd at the centre
        clear_mem();
        run_req(8'd29, 5'd29, lat);
        chk("far_lat", lat, 11);
        check_res("far", 0, 0, 0, 0, 0, 0);
        chk("far_rdrow", rd_row, 29);
        chk("far_rdcol", rd_col, 29);
        release_res("far");

        // Out-of-range request: no reads, immediate error result
        rd_moved = 1'b0;
        mon_rd   = 1'b1;
        run_req(8'd30, 5'd3, lat);
        chk("err_lat", lat, 1);
        check_res("err", 0, 0, 0, 0, 0, 1);
        chk("err_busy", busy, 1);
        release_res("err");
        mon_rd = 1'b0;
        chk("err_rd_hold", rd_moved, 0);

        // Backpressure on the interior pattern
        load_interior();
        run_req(8'd5, 5'd5, lat);
        chk("bp_lat", lat, 11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", res_valid, 1);
            chk("bp_ready", req_ready, 0);
            check_res("bp", 3, 1, 3, 12, 0, 0);
        end
        release_res("bp");

        // Reset pulse during slot 4
        @(negedge clk);
        req_row   = 8'd5;
        req_col   = 5'd5;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", res_valid, 0);
        chk("mid_busy",  busy,      0);
        chk("mid_ready", req_ready, 1);
        chk("mid_rdrow", rd_row,    0);
        chk("mid_rdcol", rd_col,    0);
        chk("mid_cnt",   res_nbr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        early_valid = 0;
        repeat (14) begin
            @(negedge clk);
            if (res_valid) early_valid++;
        end
        chk("mid_no_partial", early_valid, 0);

        load_interior();
        run_req(8'd5, 5'd5, lat);
        chk("post_lat", lat, 11);
        check_res("post", 3, 1, 3, 12, 0, 0);
        release_res("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fcc_neighbor_scan_ctrl.md
Name: fcc_neighbor_scan_ctrl

Overview:
- Sequencer that owns the read port of the FCC point label memory.
- Per accepted request for a centre cell (row, col), it reads the centre and its 8 grid neighbours, one address per cycle, through the memory's 1-cycle registered read.
- It reduces the returned labels to a minimum neighbour label, a qualifying-neighbour count and the centre status.
- It feeds the FCC labelling pipeline through valid/ready handshakes on both sides.

Parameters:
- ROWS, 30, grid rows
- COLS, 30, grid columns
- COL_W, 5, column index width
- LABEL_W, 16, label width; label 0 means unlabelled

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_row  in  8  centre row
- req_col  in  COL_W  centre column
- rd_row  out  8  memory read row, registered
- rd_col  out  COL_W  memory read column, registered
- rd_label  in  LABEL_W  memory data, valid the cycle after the address
- rd_is_ground  in  1  memory ground flag, same timing as rd_label
- res_valid  out  1  result present
- res_ready  in  1  result consumed
- res_min_label  out  LABEL_W  smallest qualifying neighbour label, 0 if none
- res_found  out  1  at least one qualifying neighbour
- res_nbr_cnt  out  4  number of qualifying neighbours, 0..8
- res_center_label  out  LABEL_W  centre cell label
- res_center_ground  out  1  centre cell ground flag
- res_err  out  1  request was out of range
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-scan):
  - state = IDLE, slot counter = 0.
  - All res_* outputs = 0, rd_row = 0, rd_col = 0, req_ready = 1.
  - Any in-flight scan is abandoned; no partial result is ever presented.
- States and transitions:
  - IDLE -> SCAN on req_valid & req_ready with an in-range request.
  - IDLE -> DONE with res_err = 1 (no reads issued) when req_row >= ROWS or req_col >= COLS.
  - SCAN: 9 cycles, slot k = 0..8.
  - SCAN -> DRAIN after slot 8.
  - DRAIN: 1 cycle; captures slot 8 data.
  - DRAIN -> DONE.
  - DONE: res_valid = 1. DONE -> IDLE on res_ready.
- Slot order, as (dr, dc):
  - 0 (-1,-1), 1 (-1,0), 2 (-1,+1), 3 (0,-1), 4 (0,0) centre, 5 (0,+1), 6 (+1,-1), 7 (+1,0), 8 (+1,+1).
- Addressing:
  - rd_row/rd_col are registered and hold slot k's address during SCAN cycle k.
  - A slot is in-bounds iff 0 <= row+dr < ROWS and 0 <= col+dc < COLS; compute with 1 extra sign bit, no wrap-around.
  - An out-of-bounds slot still consumes its cycle (fixed latency). It drives the centre address and carries valid = 0; its data is ignored.
  - A slot-valid bit and slot index are delayed 1 cycle to align with rd_label.
- Reduction, when aligned data arrives:
  - Centre slot: load res_center_label / res_center_ground only; the centre never counts as a neighbour.
  - Neighbour slot qualifies iff in-bounds & rd_label != 0 & !rd_is_ground.
  - A qualifying slot increments the count; min = smaller of the running min and rd_label (unsigned).
  - Running min initialises to all-ones on accept. If count = 0 at DRAIN end, res_min_label = 0 and res_found = 0.
- Latency: accept edge at cycle T; slot k address at T+1+k; DRAIN at T+10; res_valid high from T+11 (constant for every in-range request). Out-of-range request: res_valid at T+1.
- Output stability: res_* are stable while res_valid = 1 and res_ready = 0; they are cleared on the return to IDLE.
- req_ready = 0 outside IDLE; back-to-back requests are separated by at least one IDLE cycle.
- Request held while in DONE is not accepted until IDLE.

Decomposition:
- Package fcc_scan_pkg:
  - state enum (IDLE, SCAN, DRAIN, DONE)
  - SLOT_N = 9, CENTRE_SLOT = 4
  - constant dr/dc offset tables
  - LABEL_MAX (all-ones) constant
- Sub-module fcc_nbr_addr_gen (combinational): centre row/col + slot -> address + in_bounds, using the same ROWS/COLS/COL_W parameters.

Test Plan:
- Interior centre (5,5). Memory: (4,4)=7, (4,6)=3, (6,5)=9, (5,4)=ground with label 2, (5,5)=12, others 0 -> res_min_label=3, res_found=1, res_nbr_cnt=3, res_center_label=12, res_center_ground=0, res_valid at T+11.
- Corner (0,0). Neighbours (0,1)=5, (1,0)=4, (1,1)=0 -> only 3 in-bounds slots read, min=4, cnt=2; latency still T+11; rd_row never shows 255.
- Far corner (29,29), all labels 0 -> res_found=0, res_min_label=0, res_nbr_cnt=0.
- Request (30,3) -> res_err=1, no address changes, res_valid at T+1.
- Backpressure: res_ready low for 5 cycles after res_valid -> outputs constant, req_ready=0 throughout; IDLE one cycle after res_ready.
- Reset pulse at SCAN slot 4 -> outputs zeroed immediately. A new request at (5,5) then returns the same values as the first scenario.
